// File: rtl/quad_decoder_counter.sv
// Quadrature A/B decoder with x4 position counter, direction, step strobe and sticky error.
// Optional input glitch filter enabled by defining QDEC_GLITCH_FILTER_EN.
module quad_decoder_counter #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int FILL = SYNC_STAGES + 1;
`else
  localparam int FILL = SYNC_STAGES;
`endif
  localparam int FW = $clog2(FILL + 1);

  // Position of a phase state along the up sequence 00->10->11->01.
  function automatic logic [1:0] phase_pos(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
  logic [1:0]             s;
  logic                   dec_valid;
  logic [FW-1:0]          fill_q, fill_d;
  logic [1:0]             p_q, p_d;
  logic                   primed_q, primed_d;
  logic [WIDTH-1:0]       count_q, count_d;
  logic                   dir_q, dir_d;
  logic                   step_q, step_d;
  logic                   err_q, err_d;
  logic                   err_set;
  logic [1:0]             delta;

  // Input synchronizer chains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sync_q <= {SYNC_STAGES{1'b0}};
      b_sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a_in};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b_in};
    end
  end

  assign s = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

`ifdef QDEC_GLITCH_FILTER_EN
  logic [1:0] prev_s_q;

  // Previous sample, so only states seen on two consecutive samples are decoded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_s_q <= 2'b00;
    end else begin
      prev_s_q <= s;
    end
  end

  assign dec_valid = (s == prev_s_q);
`else
  assign dec_valid = 1'b1;
`endif

  assign delta = phase_pos(s) - phase_pos(p_q);

  // Priming, transition decode, count/dir/step/err next state.
  always_comb begin
    fill_d   = fill_q;
    p_d      = p_q;
    primed_d = primed_q;
    count_d  = count_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    err_set  = 1'b0;

    // Priming waits until the chain holds real samples rather than reset values.
    if (fill_q != FW'(FILL)) begin
      fill_d = fill_q + FW'(1);
    end else begin
      fill_d = fill_q;
    end

    if (!primed_q) begin
      if ((fill_q == FW'(FILL)) && dec_valid) begin
        p_d      = s;
        primed_d = 1'b1;
      end else begin
        p_d = p_q;
      end
    end else if (dec_valid && (s != p_q)) begin
      p_d = s;
      case (delta)
        2'd1: begin
          count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
          dir_d   = 1'b1;
          step_d  = 1'b1;
        end
        2'd3: begin
          count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
          dir_d   = 1'b0;
          step_d  = 1'b1;
        end
        2'd2: begin
          err_set = 1'b1;
        end
        default: begin
          err_set = 1'b0;
        end
      endcase
    end else begin
      p_d = p_q;
    end

    if (clr) begin
      count_d = {WIDTH{1'b0}};
    end else begin
      count_d = count_d;
    end

    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Decoder state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q   <= {FW{1'b0}};
      p_q      <= 2'b00;
      primed_q <= 1'b0;
      count_q  <= {WIDTH{1'b0}};
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      fill_q   <= fill_d;
      p_q      <= p_d;
      primed_q <= primed_d;
      count_q  <= count_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      err_q    <= err_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign step  = step_q;
  assign err   = err_q;

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Scoreboard bench for quad_decoder_counter: each step pulse is matched against a queued expectation.
module tb_quad_decoder_counter;

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       a_in, b_in, clr, err_clr;
  logic [7:0] count;
  logic       dir, step, err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         ecyc;
    logic [7:0] ecount;
    logic       edir;
    logic       eerr;
  } exp_t;

  exp_t exp_q[$];

  quad_decoder_counter #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .clr(clr), .err_clr(err_clr),
    .count(count), .dir(dir), .step(step), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every step pulse pops one expectation.
  always @(negedge clk) begin
    if (step === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_step: got step=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("step_cycle", cyc, e.ecyc);
        chk("step_count", int'(count), int'(e.ecount));
        chk("step_dir", int'(dir), int'(e.edir));
        chk("step_err", int'(err), int'(e.eerr));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_ab(input logic a, input logic b, input logic exp_step,
                          input logic [7:0] ec, input logic ed, input logic ee);
    exp_t e;
    @(negedge clk);
    a_in = a;
    b_in = b;
    if (exp_step) begin
      e.ecyc   = cyc + LAT + 1;
      e.ecount = ec;
      e.edir   = ed;
      e.eerr   = ee;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; a_in = 1'b0; b_in = 1'b0; clr = 1'b0; err_clr = 1'b0;
    idle(3);
    chk("rst_count", int'(count), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    idle(6);

    // Up count through one full cycle.
    drive_ab(1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0); idle(3);
    drive_ab(1'b1, 1'b1, 1'b1, 8'd2, 1'b1, 1'b0); idle(3);
    drive_ab(1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 1'b0); idle(3);
    drive_ab(1'b0, 1'b0, 1'b1, 8'd4, 1'b1, 1'b0); idle(3);
    chk("up_count", int'(count), 4);
    chk("up_dir", int'(dir), 1);

    // Clear, then down step wraps to 255.
    clr = 1'b1; idle(1); clr = 1'b0; idle(1);
    chk("clr_count", int'(count), 0);
    drive_ab(1'b0, 1'b1, 1'b1, 8'd255, 1'b0, 1'b0); idle(4);
    chk("wrap_count", int'(count), 255);
    chk("wrap_dir", int'(dir), 0);
    drive_ab(1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0); idle(4);

    // Illegal transition 00->11, then clear err, then legal step.
    drive_ab(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0); idle(4);
    chk("illegal_err", int'(err), 1);
    chk("illegal_count", int'(count), 0);
    chk("illegal_dir", int'(dir), 1);
    err_clr = 1'b1; idle(1); err_clr = 1'b0; idle(1);
    chk("errclr_err", int'(err), 0);
    drive_ab(1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0); idle(4);
    chk("after_illegal_count", int'(count), 1);

    // Priming: reset released with a=b=1.
    rst = 1'b1; a_in = 1'b1; b_in = 1'b1;
    idle(3);
    chk("rst2_count", int'(count), 0);
    rst = 1'b0;
    idle(6);
    chk("prime_count", int'(count), 0);
    chk("prime_err", int'(err), 0);
    drive_ab(1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0); idle(3);
    chk("prime_step_count", int'(count), 1);

    // Advance to count 5.
    drive_ab(1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0); idle(3);
    drive_ab(1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0); idle(3);
    drive_ab(1'b1, 1'b1, 1'b1, 8'd4, 1'b1, 1'b0); idle(3);
    drive_ab(1'b0, 1'b1, 1'b1, 8'd5, 1'b1, 1'b0); idle(3);
    chk("five_count", int'(count), 5);

    // clr on the same edge as a legal up step.
    drive_ab(1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0);
    idle(LAT); clr = 1'b1; idle(1); clr = 1'b0; idle(2);
    chk("clr_collide_count", int'(count), 0);

    // err_clr on the same edge as an illegal step.
    drive_ab(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    idle(LAT); err_clr = 1'b1; idle(1); err_clr = 1'b0; idle(2);
    chk("errclr_collide_err", int'(err), 1);
    chk("errclr_collide_count", int'(count), 0);

    // Back to 00 with err still sticky, then clear it.
    drive_ab(1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 1'b1); idle(3);
    drive_ab(1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b1); idle(3);
    err_clr = 1'b1; idle(1); err_clr = 1'b0; idle(1);
    chk("errclr2_err", int'(err), 0);

    // One-cycle glitch on a_in.
`ifdef QDEC_GLITCH_FILTER_EN
    drive_ab(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    drive_ab(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    idle(6);
    chk("glitch_count", int'(count), 2);
    drive_ab(1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0); idle(5);
    chk("stable_count", int'(count), 3);
`else
    drive_ab(1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0);
    drive_ab(1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
    idle(6);
    chk("glitch_count", int'(count), 2);
    chk("glitch_dir", int'(dir), 0);
`endif

    idle(6);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
